// File: rtl/urf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : urf_pkg
// Description : Shared constants for the UART frame router (framing bytes,
//               rejection codes, parser state encoding).
// Revision    : 1.0 - initial release
// ============================================================================
package urf_pkg;

  localparam logic [7:0] HDR0 = 8'h55;
  localparam logic [7:0] HDR1 = 8'hA5;
  localparam logic [7:0] TAIL = 8'hF0;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_TAIL    = 3'd1;
  localparam logic [2:0] ERR_CHK     = 3'd2;
  localparam logic [2:0] ERR_ID      = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;
  localparam logic [2:0] ERR_OVERRUN = 3'd5;

  localparam logic [1:0] ST_HUNT0   = 2'd0;
  localparam logic [1:0] ST_HUNT1   = 2'd1;
  localparam logic [1:0] ST_PAYLOAD = 2'd2;
  localparam logic [1:0] ST_TAIL    = 2'd3;

endpackage
`default_nettype wire

// File: rtl/urf_gap_timer.sv
`default_nettype none
// ============================================================================
// Module      : urf_gap_timer
// Description : Inter-byte gap counter; flags expiry after TIMEOUT_CYC cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module urf_gap_timer #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || !run_i) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = run_i && (cnt_q == LIMIT);

endmodule
`default_nettype wire

// File: rtl/uart_frame_router.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_router
// Description : Parses 0x55 0xA5 <payload> 0xF0 frames from a UART byte stream
//               and hands accepted payloads to one of NUM_CH channels.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_router #(
  parameter int NUM_CH        = 2,
  parameter int PAYLOAD_BYTES = 7,
  parameter int CHK_MODE      = 0,
  parameter int TIMEOUT_CYC   = 50000
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  output logic [NUM_CH-1:0]          ch_valid,
  input  logic [NUM_CH-1:0]          ch_ready,
  output logic [PAYLOAD_BYTES*8-1:0] ch_data,
  output logic                       err_pulse,
  output logic [2:0]                 err_code,
  output logic [15:0]                frame_cnt
);
  import urf_pkg::*;

  localparam int DW = PAYLOAD_BYTES * 8;
  localparam int IW = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(PAYLOAD_BYTES - 1);

  logic [1:0]        state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DW-1:0]     buf_q, buf_d;
  logic [DW-1:0]     data_q;
  logic [NUM_CH-1:0] valid_q;
  logic              err_pulse_q;
  logic [2:0]        err_code_q, err_d;
  logic [15:0]       cnt_q;
  logic              load;

  logic              w_timeout;
  logic [1:0]        w_cur;
  logic [7:0]        w_id;
  logic [7:0]        w_xor;
  logic              w_id_bad;
  logic              w_pending;
  logic              w_handshake;
  logic [NUM_CH-1:0] w_onehot;

  urf_gap_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_gap_timer (
    .clk_i     (Clk),
    .rst_i     (Rst),
    .clear_i   (rx_valid | w_timeout),
    .run_i     (state_q != ST_HUNT0),
    .expired_o (w_timeout)
  );

  // A timeout coinciding with a byte lets that byte be parsed from HUNT0.
  assign w_cur       = w_timeout ? ST_HUNT0 : state_q;
  assign w_id        = buf_q[DW-1 -: 8];
  assign w_id_bad    = ({24'd0, w_id} >= 32'(NUM_CH));
  assign w_onehot    = NUM_CH'(1) << w_id;
  assign w_pending   = |valid_q;
  assign w_handshake = |(valid_q & ch_ready);

  always_comb begin
    w_xor = '0;
    for (int i = 0; i < PAYLOAD_BYTES; i++) begin
      w_xor = w_xor ^ buf_q[i*8 +: 8];
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= ST_HUNT0;
      idx_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    if (w_timeout) begin
      state_d = ST_HUNT0;
      idx_d   = '0;
    end
    if (rx_valid) begin
      unique case (w_cur)
        ST_HUNT0: begin
          state_d = (rx_data == HDR0) ? ST_HUNT1 : ST_HUNT0;
        end
        ST_HUNT1: begin
          if (rx_data == HDR1) begin
            state_d = ST_PAYLOAD;
            idx_d   = '0;
          end else if (rx_data != HDR0) begin
            state_d = ST_HUNT0;
          end
        end
        ST_PAYLOAD: begin
          buf_d = {buf_q[DW-9:0], rx_data};
          if (idx_q == LAST_IDX) begin
            state_d = ST_TAIL;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_HUNT0;
        end
      endcase
    end
  end

  // A handshake in the same cycle frees the output slot, so it is not an overrun.
  always_comb begin
    err_d = ERR_NONE;
    load  = 1'b0;
    if (w_timeout) begin
      err_d = ERR_TIMEOUT;
    end else if (rx_valid && (state_q == ST_TAIL)) begin
      if (rx_data != TAIL) begin
        err_d = ERR_TAIL;
      end else if ((CHK_MODE == 1) && (w_xor != 8'd0)) begin
        err_d = ERR_CHK;
      end else if (w_id_bad) begin
        err_d = ERR_ID;
      end else if (w_pending && !w_handshake) begin
        err_d = ERR_OVERRUN;
      end else begin
        load = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      data_q      <= '0;
      valid_q     <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      cnt_q       <= '0;
    end else begin
      err_pulse_q <= (err_d != ERR_NONE);
      if (err_d != ERR_NONE) begin
        err_code_q <= err_d;
      end
      if (load) begin
        data_q  <= buf_q;
        valid_q <= w_onehot;
      end else if (w_handshake) begin
        valid_q <= '0;
      end
      if (w_handshake) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign ch_valid  = valid_q;
  assign ch_data   = data_q;
  assign err_pulse = err_pulse_q;
  assign err_code  = err_code_q;
  assign frame_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_frame_router
// Description : Self-checking bench; two routers (CHK_MODE 0 and 1) share one
//               byte stream and are compared against a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_frame_router;

  localparam int NCH = 2;
  localparam int PB  = 7;
  localparam int TO  = 40;
  localparam int DW  = PB * 8;

  logic           clk      = 1'b0;
  logic           rst      = 1'b1;
  logic [7:0]     rx_data  = 8'h00;
  logic           rx_valid = 1'b0;
  logic [NCH-1:0] rdy [2]  = '{default: '0};
  logic [NCH-1:0] chv [2];
  logic [DW-1:0]  chd [2];
  logic           ep  [2];
  logic [2:0]     ec  [2];
  logic [15:0]    fc  [2];

  int nchk  = 0;
  int nfail = 0;

  int         got_n [2] = '{0, 0};
  logic [2:0] got_c [2] = '{3'd0, 3'd0};

  bit          mpend [2];
  logic [7:0]  mch   [2];
  logic [DW-1:0] mdata [2];
  logic [15:0] mcnt  [2];
  int          exp_n [2] = '{0, 0};
  logic [2:0]  exp_c [2];

  logic [7:0] pl [PB];

  always #5 clk = ~clk;

  uart_frame_router #(.NUM_CH(NCH), .PAYLOAD_BYTES(PB), .CHK_MODE(0), .TIMEOUT_CYC(TO)) dut0 (
    .Clk(clk), .Rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .ch_valid(chv[0]), .ch_ready(rdy[0]), .ch_data(chd[0]),
    .err_pulse(ep[0]), .err_code(ec[0]), .frame_cnt(fc[0]));

  uart_frame_router #(.NUM_CH(NCH), .PAYLOAD_BYTES(PB), .CHK_MODE(1), .TIMEOUT_CYC(TO)) dut1 (
    .Clk(clk), .Rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .ch_valid(chv[1]), .ch_ready(rdy[1]), .ch_data(chd[1]),
    .err_pulse(ep[1]), .err_code(ec[1]), .frame_cnt(fc[1]));

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ep[k] === 1'b1) begin
        got_n[k] = got_n[k] + 1;
        got_c[k] = ec[k];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    assert (act === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mpend[k] = 1'b0;
      mch[k]   = 8'd0;
      mdata[k] = '0;
      mcnt[k]  = 16'd0;
    end
  endtask

  task automatic model_err(input int k, input logic [2:0] code);
    exp_n[k] = exp_n[k] + 1;
    exp_c[k] = code;
  endtask

  task automatic model_deliver();
    for (int k = 0; k < 2; k++) begin
      if (mpend[k]) begin
        mpend[k] = 1'b0;
        mcnt[k]  = mcnt[k] + 16'd1;
      end
    end
  endtask

  // Frame outcome from the framing rules; instance 1 applies the XOR check.
  task automatic model_frame(input logic [7:0] tail, input bit rdy_on_tail);
    logic [7:0]    x;
    logic [DW-1:0] packed_pl;
    x = 8'd0;
    packed_pl = '0;
    for (int i = 0; i < PB; i++) begin
      x = x ^ pl[i];
      packed_pl = {packed_pl[DW-9:0], pl[i]};
    end
    if (rdy_on_tail) model_deliver();
    for (int k = 0; k < 2; k++) begin
      if (tail != 8'hF0)              model_err(k, 3'd1);
      else if (k == 1 && x != 8'd0)   model_err(k, 3'd2);
      else if (pl[0] >= NCH)          model_err(k, 3'd3);
      else if (mpend[k])              model_err(k, 3'd5);
      else begin
        mpend[k] = 1'b1;
        mch[k]   = pl[0];
        mdata[k] = packed_pl;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit r);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    rdy[0]   = r ? '1 : '0;
    rdy[1]   = r ? '1 : '0;
    @(negedge clk);
    rx_valid = 1'b0;
    rdy[0]   = '0;
    rdy[1]   = '0;
  endtask

  task automatic send_frame(input logic [7:0] tail, input bit rdy_on_tail);
    send_byte(8'h55, 1'b0);
    send_byte(8'hA5, 1'b0);
    for (int i = 0; i < PB; i++) send_byte(pl[i], 1'b0);
    send_byte(tail, rdy_on_tail);
    model_frame(tail, rdy_on_tail);
  endtask

  task automatic handshake();
    @(negedge clk);
    rdy[0] = '1;
    rdy[1] = '1;
    @(negedge clk);
    rdy[0] = '0;
    rdy[1] = '0;
    model_deliver();
  endtask

  task automatic set_pl(input logic [8*PB-1:0] v);
    for (int i = 0; i < PB; i++) pl[i] = v[8*(PB-1-i) +: 8];
  endtask

  task automatic fix_xor();
    logic [7:0] x;
    x = 8'd0;
    for (int i = 0; i < PB - 1; i++) x = x ^ pl[i];
    pl[PB-1] = x;
  endtask

  task automatic verify(input string tag);
    logic [NCH-1:0] ev;
    repeat (2) @(negedge clk);
    #2;
    for (int k = 0; k < 2; k++) begin
      ev = mpend[k] ? (NCH'(1) << mch[k]) : '0;
      chk($sformatf("%s d%0d ch_valid", tag, k), 64'(chv[k]), 64'(ev));
      chk($sformatf("%s d%0d ch_data", tag, k), 64'(chd[k]), 64'(mdata[k]));
      chk($sformatf("%s d%0d frame_cnt", tag, k), 64'(fc[k]), 64'(mcnt[k]));
      chk($sformatf("%s d%0d err_count", tag, k), 64'(got_n[k]), 64'(exp_n[k]));
      if (exp_n[k] > 0) chk($sformatf("%s d%0d err_code", tag, k), 64'(got_c[k]), 64'(exp_c[k]));
    end
  endtask

  initial begin
    logic [7:0] t;
    model_reset();
    repeat (3) @(negedge clk);
    verify("reset");
    rst = 1'b0;

    set_pl(56'h00008000000000);
    send_frame(8'hF0, 1'b0);
    verify("f037");
    handshake();
    verify("f037_hs");

    set_pl(56'h01043505060708);
    send_frame(8'hF0, 1'b0);
    verify("f038");
    handshake();
    verify("f038_hs");

    send_byte(8'h12, 1'b0);
    send_byte(8'h55, 1'b0);
    set_pl(56'h01000000000000);
    send_frame(8'hF0, 1'b0);
    verify("resync");
    handshake();
    send_frame(8'hE0, 1'b0);
    verify("badtail");

    set_pl(56'h01020300000007);
    send_frame(8'hF0, 1'b0);
    verify("badxor");
    handshake();
    set_pl(56'h01020300000000);
    send_frame(8'hF0, 1'b0);
    verify("goodxor");
    handshake();
    set_pl(56'h05000000000005);
    send_frame(8'hF0, 1'b0);
    verify("badid");

    set_pl(56'h00112233445566);
    fix_xor();
    send_frame(8'hF0, 1'b0);
    set_pl(56'h01AABBCCDDEEFF);
    fix_xor();
    send_frame(8'hF0, 1'b0);
    verify("overrun");

    set_pl(56'h01393837363534);
    fix_xor();
    send_frame(8'hF0, 1'b1);
    verify("hs_same_cycle");
    handshake();

    send_byte(8'h55, 1'b0);
    send_byte(8'hA5, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i), 1'b0);
    repeat (TO + 10) @(negedge clk);
    model_err(0, 3'd4);
    model_err(1, 3'd4);
    verify("timeout");
    set_pl(56'h00C0FFEE123456);
    fix_xor();
    send_frame(8'hF0, 1'b0);
    verify("after_timeout");

    for (int n = 0; n < 24; n++) begin
      for (int j = 0; j < int'($urandom_range(0, 3)); j++) begin
        t = 8'($urandom_range(0, 255));
        if (t == 8'h55) t = 8'h00;
        send_byte(t, 1'b0);
      end
      for (int i = 0; i < PB; i++) pl[i] = 8'($urandom_range(0, 255));
      pl[0] = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) fix_xor();
      t = 8'hF0;
      if ($urandom_range(0, 4) == 0) begin
        t = 8'($urandom_range(0, 255));
        if (t == 8'hF0) t = 8'h0F;
      end
      send_frame(t, $urandom_range(0, 3) == 0);
      verify("rand");
      if ($urandom_range(0, 1) == 1) begin
        handshake();
        verify("rand_hs");
      end
    end

    set_pl(56'h01000000000001);
    send_frame(8'hF0, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'hA5, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'h77, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("midrst d%0d ch_valid", k), 64'(chv[k]), 64'd0);
      chk($sformatf("midrst d%0d ch_data", k), 64'(chd[k]), 64'd0);
      chk($sformatf("midrst d%0d frame_cnt", k), 64'(fc[k]), 64'd0);
      chk($sformatf("midrst d%0d err_pulse", k), 64'(ep[k]), 64'd0);
      chk($sformatf("midrst d%0d err_code", k), 64'(ec[k]), 64'd0);
    end
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    verify("post_reset");
    set_pl(56'h00010203040506);
    fix_xor();
    send_frame(8'hF0, 1'b0);
    verify("post_reset_frame");

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
`default_nettype wire
